reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Single-clock controller that sequences the board reset tree: holds the PLL in reset, waits for a stable lock, then releases the per-domain resets one at a time in a fixed order.
- Retries the PLL on lock timeout and latches a fault after repeated failures.
- Sits between the soft/hard reset combine and the per-domain reset synchronisers; its o_domain_reset_n bits feed those synchronisers' async reset inputs.

Parameters:
- NUM_DOMAINS, 3, number of clock-domain resets released in order, index 0 first.
- PLL_RESET_CYCLES, 16, cycles o_pll_reset is held high per attempt; minimum 1.
- LOCK_STABLE_CYCLES, 64, consecutive cycles of synchronised lock required before release; minimum 1.
- LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before the attempt fails; must exceed LOCK_STABLE_CYCLES.
- STAGE_DELAY, 8, cycles between successive domain releases; minimum 1.
- MAX_RETRIES, 3, failed lock attempts tolerated before FAULT; minimum 1.

Ports:
- i_clock, input, 1, free-running independent clock.
- i_reset, input, 1, synchronous active-high reset.
- i_pll_locked, input, 1, PLL lock, asynchronous to i_clock; synchronised internally by 2 flops.
- i_soft_reset_req, input, 1, single-cycle restart request, synchronous.
- o_pll_reset, output, 1, PLL reset, active high.
- o_domain_reset_n, output, NUM_DOMAINS, per-domain reset, active low.
- o_all_released, output, 1, high in RUN only.
- o_fault, output, 1, high in FAULT only.
- o_retry_count, output, $clog2(MAX_RETRIES+1), failed attempts in the current sequence.
- o_state, output, 3, encoding: PLL_RST=0, WAIT_LOCK=1, RELEASE=2, RUN=3, FAULT=4.

Behaviour:
- All outputs are registered and are direct functions of state and counters.
- Reset (i_reset high at an edge):
  - state=PLL_RST, counters=0, o_retry_count=0.
  - o_pll_reset=1, o_domain_reset_n=0, o_all_released=0, o_fault=0.
  - Lock synchroniser cleared to 0.
  - i_reset overrides every other input.
- PLL_RST:
  - o_pll_reset=1, all domains in reset.
  - After PLL_RESET_CYCLES cycles in this state, go to WAIT_LOCK; o_pll_reset falls on that transition.
- WAIT_LOCK:
  - stable counter increments while synced lock=1 and clears to 0 when it is 0.
  - timeout counter increments every cycle.
  - When stable reaches LOCK_STABLE_CYCLES, go to RELEASE.
  - When timeout reaches LOCK_TIMEOUT first, increment retries. If the new count equals MAX_RETRIES, go to FAULT; otherwise go to PLL_RST.
  - If both limits are reached in the same cycle, success wins.
- RELEASE:
  - Stage index k starts at 0. Every STAGE_DELAY cycles, set o_domain_reset_n[k]=1 and increment k.
  - The first release happens STAGE_DELAY cycles after entry.
  - After bit NUM_DOMAINS-1 is released, go to RUN; o_all_released=1 in the same cycle as the last release.
- RUN:
  - All bits of o_domain_reset_n=1.
  - Holds until lock loss or a soft request.
- Lock loss (synced lock=0) in RELEASE or RUN:
  - Next edge: state=PLL_RST, all o_domain_reset_n=0 simultaneously, o_all_released=0.
  - Retries are NOT incremented.
- i_soft_reset_req in any state (including FAULT and mid-RELEASE):
  - Next edge: state=PLL_RST, all counters and retries cleared, all domains back in reset.
  - A request arriving in PLL_RST restarts the PLL_RESET_CYCLES count.
  - Soft request beats lock loss and timeout in the same cycle.
- FAULT:
  - o_fault=1, o_pll_reset=1, all domains in reset.
  - Exits only on i_soft_reset_req or i_reset.
- Saturation and widths:
  - o_retry_count saturates at MAX_RETRIES.
  - Counters are sized $clog2(max param + 1) and never wrap; they are cleared on every state entry.
- Invariant: o_domain_reset_n is thermometer-coded from bit 0 at all times; a higher bit is never released before a lower one.

Test Plan:
Bench parameters for all cases: NUM_DOMAINS=3, PLL_RESET_CYCLES=4, LOCK_STABLE_CYCLES=4, LOCK_TIMEOUT=32, STAGE_DELAY=2, MAX_RETRIES=2.
1. Nominal bring-up: i_reset dropped, i_pll_locked=1 throughout.
   - o_pll_reset=1 for 4 cycles; WAIT_LOCK lasts 2 sync + 4 stable cycles.
   - o_domain_reset_n goes 001, 011, 111 at 2-cycle spacing.
   - o_all_released rises with 111; o_state=3.
2. Lock glitch in WAIT_LOCK: lock=1 for 3 cycles, 0 for 1 cycle, then 1.
   - Stable count restarts; release begins only after 4 further consecutive locked cycles.
   - o_retry_count stays 0.
3. Timeout and fault: lock held 0.
   - After 32 WAIT_LOCK cycles, o_retry_count=1 and the sequence returns to PLL_RST (o_pll_reset=1 for 4 cycles).
   - After a second timeout, o_retry_count=2, o_state=4, o_fault=1, outputs frozen.
   - i_soft_reset_req then gives o_state=0, o_fault=0, o_retry_count=0.
4. Lock loss mid-RELEASE: drop lock when o_domain_reset_n=001.
   - 2 cycles later (sync latency) plus 1 edge: o_domain_reset_n=000, o_state=0, o_retry_count unchanged.
5. Soft reset in RUN, same cycle as lock loss.
   - Next edge: o_state=0, all counters 0, o_domain_reset_n=000, o_all_released=0.
   - Full nominal sequence then repeats with identical timing to scenario 1.
6. i_reset pulsed for 1 cycle mid-RELEASE.
   - All outputs return to their reset values on that edge.
   - The thermometer invariant holds throughout; checked by assertion every cycle.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds the PLL in reset, waits for stable lock, then releases domain resets in order.
//   i_clock, i_reset        : clock and synchronous active-high reset
//   i_pll_locked            : asynchronous PLL lock, double-flop synchronised here
//   i_soft_reset_req        : single-cycle restart request
//   o_pll_reset             : PLL reset, active high
//   o_domain_reset_n        : per-domain resets, active low, released from bit 0 upward
//   o_all_released, o_fault : high in RUN / FAULT only
//   o_retry_count, o_state  : failed lock attempts and current state
module reset_sequencer #(
    parameter int NUM_DOMAINS        = 3,
    parameter int PLL_RESET_CYCLES   = 16,
    parameter int LOCK_STABLE_CYCLES = 64,
    parameter int LOCK_TIMEOUT       = 4096,
    parameter int STAGE_DELAY        = 8,
    parameter int MAX_RETRIES        = 3
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_pll_locked,
    input  logic                           i_soft_reset_req,
    output logic                           o_pll_reset,
    output logic [NUM_DOMAINS-1:0]         o_domain_reset_n,
    output logic                           o_all_released,
    output logic                           o_fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0] o_retry_count,
    output logic [2:0]                     o_state
);
    localparam int MAXA = LOCK_TIMEOUT > PLL_RESET_CYCLES ? LOCK_TIMEOUT : PLL_RESET_CYCLES;
    localparam int MAXC = MAXA > STAGE_DELAY ? MAXA : STAGE_DELAY;
    localparam int CW = $clog2(MAXC + 1);
    localparam int KW = $clog2(NUM_DOMAINS + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam logic [CW-1:0] PLL_LAST   = CW'(PLL_RESET_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_N   = CW'(LOCK_STABLE_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_N  = CW'(LOCK_TIMEOUT);
    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
    localparam logic [KW-1:0] K_LAST     = KW'(NUM_DOMAINS - 1);
    localparam logic [RW-1:0] R_MAX      = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d, stable_q, stable_d;
    logic [KW-1:0]          k_q, k_d;
    logic [RW-1:0]          retry_q, retry_d;
    logic [1:0]             sync_q;
    logic                   pll_q, pll_d, all_q, all_d, fault_q, fault_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   lock_s, hold;

    assign lock_s = sync_q[1];
    // Lock seen while the PLL is held in reset is stale, so the synchroniser is kept clear then.
    assign hold = (state_q == PLL_RST) || (state_q == FAULT);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        k_d      = k_q;
        retry_d  = retry_q;
        if (i_soft_reset_req) begin
            state_d  = PLL_RST;
            cnt_d    = '0;
            stable_d = '0;
            k_d      = '0;
            retry_d  = '0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    cnt_d   = cnt_q == PLL_LAST ? '0 : cnt_q + 1'b1;
                    state_d = cnt_q == PLL_LAST ? WAIT_LOCK : PLL_RST;
                end
                WAIT_LOCK: begin
                    stable_d = lock_s ? stable_q + 1'b1 : '0;
                    cnt_d    = cnt_q + 1'b1;
                    // Success is tested first so it wins a tie with the timeout.
                    if (stable_d == STABLE_N) begin
                        state_d  = RELEASE;
                        cnt_d    = '0;
                        stable_d = '0;
                    end else if (cnt_d == TIMEOUT_N) begin
                        retry_d  = retry_q == R_MAX ? retry_q : retry_q + 1'b1;
                        state_d  = retry_d == R_MAX ? FAULT : PLL_RST;
                        cnt_d    = '0;
                        stable_d = '0;
                    end
                end
                RELEASE: begin
                    if (!lock_s) begin
                        state_d = PLL_RST;
                        cnt_d   = '0;
                        k_d     = '0;
                    end else if (cnt_q == STAGE_LAST) begin
                        cnt_d   = '0;
                        k_d     = k_q + 1'b1;
                        state_d = k_q == K_LAST ? RUN : RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    state_d = lock_s ? RUN : PLL_RST;
                    k_d     = lock_s ? k_q : '0;
                end
                FAULT: ;
                default: begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                    k_d     = '0;
                end
            endcase
        end
        pll_d   = (state_d == PLL_RST) || (state_d == FAULT);
        all_d   = state_d == RUN;
        fault_d = state_d == FAULT;
        // k_d counts released domains, so the enable mask is a thermometer of k_d.
        for (int j = 0; j < NUM_DOMAINS; j++) begin
            dom_d[j] = (state_d == RUN) || ((state_d == RELEASE) && (k_d > KW'(j)));
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= PLL_RST;
            cnt_q    <= '0;
            stable_q <= '0;
            k_q      <= '0;
            retry_q  <= '0;
            sync_q   <= '0;
            pll_q    <= 1'b1;
            dom_q    <= '0;
            all_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            k_q      <= k_d;
            retry_q  <= retry_d;
            sync_q   <= hold ? 2'b00 : {sync_q[0], i_pll_locked};
            pll_q    <= pll_d;
            dom_q    <= dom_d;
            all_q    <= all_d;
            fault_q  <= fault_d;
        end
    end

    assign o_pll_reset      = pll_q;
    assign o_domain_reset_n = dom_q;
    assign o_all_released   = all_q;
    assign o_fault          = fault_q;
    assign o_retry_count    = retry_q;
    assign o_state          = state_q;
endmodule
